// File: rtl/gray_2x2_window_gen_if.sv
// Raster gray stream in, 2x2 neighbourhood stream out.
// The master drives the raster input; the slave produces the window.
interface gray_2x2_window_gen_if #(
  parameter int DATA_W = 8
);
  logic              per_img_vsync;
  logic              per_img_href;
  logic [DATA_W-1:0] per_img_gray;
  logic              matrix_img_vsync;
  logic              matrix_img_href;
  logic [DATA_W-1:0] matrix_p11;
  logic [DATA_W-1:0] matrix_p12;
  logic [DATA_W-1:0] matrix_p21;
  logic [DATA_W-1:0] matrix_p22;

  modport master (
    output per_img_vsync, per_img_href, per_img_gray,
    input  matrix_img_vsync, matrix_img_href,
    input  matrix_p11, matrix_p12, matrix_p21, matrix_p22
  );

  modport slave (
    input  per_img_vsync, per_img_href, per_img_gray,
    output matrix_img_vsync, matrix_img_href,
    output matrix_p11, matrix_p12, matrix_p21, matrix_p22
  );
endinterface

// File: rtl/gray_2x2_window_gen.sv
// 2x2 window generator: one line buffer plus pixel delays, edge pixels replicated.
// Output timing equals input timing delayed by 2 clocks.
module gray_2x2_window_gen #(
  parameter int IMG_HDISP = 512,
  parameter int IMG_VDISP = 512,
  parameter int DATA_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gray_2x2_window_gen_if.slave   bus
);
  localparam int COL_W = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int ROW_W = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_HDISP - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_VDISP - 1);

  logic [DATA_W-1:0] line_buf [IMG_HDISP];

  logic [COL_W-1:0]  col_cnt;
  logic [ROW_W-1:0]  row_cnt;
  logic              frame_armed;
  logic              col_full;
  logic              vsync_p1;
  logic              href_p1;
  logic              first_col_p1;
  logic              first_row_p1;
  logic [DATA_W-1:0] cur_p1;
  logic [DATA_W-1:0] up_p1;
  logic [DATA_W-1:0] up_p2;

  logic              vsync_rise_p0;
  logic              href_fall_p0;
  logic              wr_en_p0;
  logic              first_row_p0;
  logic [DATA_W-1:0] p21_nxt;

  assign vsync_rise_p0 = bus.per_img_vsync & ~vsync_p1;
  assign href_fall_p0  = href_p1 & ~bus.per_img_href;
  assign wr_en_p0      = bus.per_img_href & (frame_armed | vsync_rise_p0) & ~col_full;
  // Pixels past the line width have no valid upper row, so treat them like row 0.
  assign first_row_p0  = vsync_rise_p0 | (row_cnt == '0) | col_full;

  // ---- stage 0 -> 1: line buffer, read-before-write ----
  always_ff @(posedge clk) begin
    if (bus.per_img_href)
      up_p1 <= line_buf[col_cnt];
    if (wr_en_p0)
      line_buf[col_cnt] <= bus.per_img_gray;
  end

  // ---- stage 0 -> 1: counters, arming, current pixel ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // vsync history resets high so a frame already in progress is not seen as a new start.
      vsync_p1     <= 1'b1;
      href_p1      <= 1'b0;
      frame_armed  <= 1'b0;
      col_cnt      <= '0;
      row_cnt      <= '0;
      col_full     <= 1'b0;
      cur_p1       <= '0;
      first_col_p1 <= 1'b0;
      first_row_p1 <= 1'b0;
    end else begin
      vsync_p1 <= bus.per_img_vsync;
      href_p1  <= bus.per_img_href;
      if (vsync_rise_p0)
        frame_armed <= 1'b1;

      if (bus.per_img_href) begin
        cur_p1       <= bus.per_img_gray;
        first_col_p1 <= (col_cnt == '0);
        first_row_p1 <= first_row_p0;
      end

      if (vsync_rise_p0)
        row_cnt <= '0;
      else if (href_fall_p0 && row_cnt != ROW_MAX)
        row_cnt <= row_cnt + ROW_W'(1);

      if (href_fall_p0) begin
        col_cnt  <= '0;
        col_full <= 1'b0;
      end else if (bus.per_img_href) begin
        if (col_cnt == COL_MAX)
          col_full <= 1'b1;
        else
          col_cnt <= col_cnt + COL_W'(1);
      end
    end
  end

  // ---- stage 1 -> 2: window assembly with edge replication ----
  assign p21_nxt = first_col_p1 ? cur_p1 : bus.matrix_p22;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.matrix_img_vsync <= 1'b0;
      bus.matrix_img_href  <= 1'b0;
      bus.matrix_p11       <= '0;
      bus.matrix_p12       <= '0;
      bus.matrix_p21       <= '0;
      bus.matrix_p22       <= '0;
      up_p2                <= '0;
    end else begin
      bus.matrix_img_vsync <= vsync_p1 & frame_armed;
      bus.matrix_img_href  <= href_p1 & frame_armed;
      if (href_p1) begin
        bus.matrix_p22 <= cur_p1;
        bus.matrix_p21 <= p21_nxt;
        bus.matrix_p12 <= first_row_p1 ? cur_p1 : up_p1;
        bus.matrix_p11 <= first_row_p1 ? p21_nxt : (first_col_p1 ? up_p1 : up_p2);
        up_p2          <= up_p1;
      end
    end
  end
endmodule
